// File: rtl/simplebus_mem_follower.sv
// simplebus_mem_follower: 64K x 8 RAM follower on the multiplexed address/data simple bus.
// Address arrives as two beats (high byte with start, low byte with read/write).
module simplebus_mem_follower #(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 8,
   parameter int READ_LATENCY = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              read,
   input  logic [DATA_W-1:0] address,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_oe,
   input  logic              dv_in,
   output logic              dv_out,
   output logic              dv_oe
);
   typedef enum logic [1:0] {IDLE, ADDR_LO, READ, WRITE} state_t;
   localparam logic [3:0] LAT = 4'(READ_LATENCY);
   state_t            state;
   logic [ADDR_W-1:0] addr_reg;
   logic [3:0]        cnt;
   logic              we;
   logic [DATA_W-1:0] mem [2**ADDR_W];
   assign we = state == WRITE && dv_in;
   always_ff @(posedge clock)
      if (we) mem[addr_reg] <= data_in;
   // data_oe is high only on the single data cycle, so the bus sees zero otherwise
   assign data_out = data_oe ? mem[addr_reg] : '0;
   // enables are registered one edge ahead so they line up with the state they belong to
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state    <= IDLE;
         addr_reg <= '0;
         cnt      <= '0;
         data_oe  <= 1'b0;
         dv_out   <= 1'b0;
         dv_oe    <= 1'b0;
      end else begin
         case (state)
            IDLE:
               if (start) begin
                  addr_reg[ADDR_W-1:DATA_W] <= address;
                  state                     <= ADDR_LO;
               end
            ADDR_LO: begin
               addr_reg[DATA_W-1:0] <= address;
               cnt                  <= '0;
               state                <= read ? READ : WRITE;
               dv_oe                <= read;
               dv_out               <= read && LAT == 4'd0;
               data_oe              <= read && LAT == 4'd0;
            end
            READ:
               if (cnt == LAT) begin
                  state   <= IDLE;
                  dv_oe   <= 1'b0;
                  dv_out  <= 1'b0;
                  data_oe <= 1'b0;
               end else begin
                  cnt     <= cnt + 4'd1;
                  dv_out  <= cnt + 4'd1 == LAT;
                  data_oe <= cnt + 4'd1 == LAT;
               end
            WRITE:
               if (dv_in) state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_simplebus_mem_follower.sv
// tb_simplebus_mem_follower: three followers (latency 2, 0, 7) on shared bus inputs,
// checked cycle by cycle against an array model of the RAM and the bus timing rules.
module tb_simplebus_mem_follower;
   logic       clock = 1'b0, reset = 1'b1, start = 1'b0, read = 1'b0, dv_in = 1'b0;
   logic [7:0] address = 8'h00, data_in = 8'h00;
   logic [7:0] dout [3];
   logic       doe [3], dvo [3], dvoe [3];
   bit   [7:0] ref_mem [65536];
   int         checks = 0, errors = 0;

   simplebus_mem_follower #(.READ_LATENCY(2)) u0 (
      .clock(clock), .reset(reset), .start(start), .read(read), .address(address),
      .data_in(data_in), .data_out(dout[0]), .data_oe(doe[0]), .dv_in(dv_in),
      .dv_out(dvo[0]), .dv_oe(dvoe[0]));
   simplebus_mem_follower #(.READ_LATENCY(0)) u1 (
      .clock(clock), .reset(reset), .start(start), .read(read), .address(address),
      .data_in(data_in), .data_out(dout[1]), .data_oe(doe[1]), .dv_in(dv_in),
      .dv_out(dvo[1]), .dv_oe(dvoe[1]));
   simplebus_mem_follower #(.READ_LATENCY(7)) u2 (
      .clock(clock), .reset(reset), .start(start), .read(read), .address(address),
      .data_in(data_in), .data_out(dout[2]), .data_oe(doe[2]), .dv_in(dv_in),
      .dv_out(dvo[2]), .dv_oe(dvoe[2]));

   always #5 clock = ~clock;

   function automatic int lat(input int i);
      return i == 0 ? 2 : i == 1 ? 0 : 7;
   endfunction

   task automatic test_reset;
      #12;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({dvoe[i], dvo[i], doe[i], dout[i]} !== 11'h0) begin
            errors++;
            $display("FAIL reset dut%0d outputs got %h want 000", i, {dvoe[i], dvo[i], doe[i], dout[i]});
         end
      end
      @(negedge clock) reset = 1'b0;
      @(posedge clock) #1;
   endtask

   // Write transaction: IDLE, ADDR_LO, hold WRITE cycles with dv_in low, then data beat.
   // Every bus output must stay quiet throughout; stray start/read/dv_in are ignored.
   task automatic do_write(input logic [15:0] a, input logic [7:0] d, input int hold);
      for (int c = 0; c < hold + 3; c++) begin
         start   = c == 0 ? 1'b1 : 1'($urandom);
         read    = c == 1 ? 1'b0 : 1'($urandom);
         address = c == 0 ? a[15:8] : c == 1 ? a[7:0] : 8'($urandom);
         dv_in   = c == hold + 2 ? 1'b1 : c >= 2 ? 1'b0 : 1'($urandom);
         data_in = c == hold + 2 ? d : 8'($urandom);
         @(negedge clock);
         for (int i = 0; i < 3; i++) begin
            checks++;
            if ({dvoe[i], dvo[i], doe[i], dout[i]} !== 11'h0) begin
               errors++;
               $display("FAIL write %h cyc%0d dut%0d outputs got %h want 000", a, c, i,
                        {dvoe[i], dvo[i], doe[i], dout[i]});
            end
         end
         @(posedge clock) #1;
      end
      start = 1'b0;
      dv_in = 1'b0;
      ref_mem[a] = d;
   endtask

   // Read transaction: entry into READ is cycle k=0; dv_oe spans k=0..L, data exactly at k=L.
   task automatic do_read(input logic [15:0] a);
      logic [10:0] e;
      int k;
      for (int c = 0; c < 11; c++) begin
         start   = c == 0 ? 1'b1 : c == 1 ? 1'($urandom) : 1'b0;
         read    = c == 1 ? 1'b1 : 1'($urandom);
         address = c == 0 ? a[15:8] : c == 1 ? a[7:0] : 8'($urandom);
         dv_in   = 1'($urandom);
         data_in = 8'($urandom);
         k = c - 2;
         @(negedge clock);
         for (int i = 0; i < 3; i++) begin
            e = {1'(k >= 0 && k <= lat(i)), 1'(k == lat(i)), 1'(k == lat(i)),
                 k == lat(i) ? ref_mem[a] : 8'h00};
            checks++;
            if ({dvoe[i], dvo[i], doe[i], dout[i]} !== e) begin
               errors++;
               $display("FAIL read %h cyc%0d dut%0d {dv_oe,dv_out,data_oe,data} got %h want %h",
                        a, c, i, {dvoe[i], dvo[i], doe[i], dout[i]}, e);
            end
         end
         @(posedge clock) #1;
      end
      start = 1'b0;
      dv_in = 1'b0;
   endtask

   // Drives the two address beats plus extra cycles, then pulses reset inside the last one.
   task automatic test_reset_mid(input logic rd, input int cycles);
      for (int c = 0; c < cycles; c++) begin
         start   = c == 0;
         read    = rd;
         address = c == 0 ? 8'h04 : 8'h06;
         dv_in   = !rd && c >= 2;
         data_in = 8'h55;
         if (c < cycles - 1) @(posedge clock) #1;
      end
      if (rd) begin
         checks++;
         if (dvoe[0] !== 1'b1) begin
            errors++;
            $display("FAIL mid_read dv_oe before reset got %b want 1", dvoe[0]);
         end
      end
      #2 reset = 1'b1;
      #1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({dvoe[i], dvo[i], doe[i], dout[i]} !== 11'h0) begin
            errors++;
            $display("FAIL reset_mid rd=%b dut%0d outputs got %h want 000", rd, i,
                     {dvoe[i], dvo[i], doe[i], dout[i]});
         end
      end
      @(negedge clock) reset = 1'b0;
      @(posedge clock) #1;
      start = 1'b0;
      dv_in = 1'b0;
   endtask

   task automatic test_random;
      logic [15:0] a;
      repeat (30) begin
         case ($urandom_range(0, 4))
            0: a = 16'h0406;
            1: a = 16'hFFFF;
            2: a = 16'h0000;
            default: a = 16'($urandom);
         endcase
         if ($urandom_range(0, 1) == 1) do_write(a, 8'($urandom), $urandom_range(0, 3));
         else do_read(a);
      end
   endtask

   initial begin
      test_reset;
      do_write(16'h0406, 8'hDC, 0);
      do_read(16'h0406);
      do_write(16'h0407, 8'hAB, 0);
      do_read(16'h0406);
      do_read(16'h0407);
      do_read(16'h1234);
      do_write(16'h0500, 8'h77, 10);
      do_read(16'h0500);
      test_reset_mid(1'b1, 4);
      do_read(16'h0406);
      test_reset_mid(1'b0, 3);
      do_read(16'h0406);
      do_write(16'hFFFF, 8'h3C, 0);
      do_write(16'h0000, 8'hC3, 0);
      do_write(16'h00FF, 8'h5A, 1);
      do_read(16'hFFFF);
      do_read(16'h0000);
      do_read(16'h00FF);
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
